// File: rtl/mouse_if_pkg.sv
// Shared definitions for the mouse event queue: register map, event record
// and the coordinate clamp used for both mouse motion and software position loads.
package mouse_if_pkg;

  localparam logic [3:0] ADDR_CTRL  = 4'd0;
  localparam logic [3:0] ADDR_STAT  = 4'd1;
  localparam logic [3:0] ADDR_EVENT = 4'd2;
  localparam logic [3:0] ADDR_POS   = 4'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CLR    = 2;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVF       = 2;
  localparam int STAT_COUNT_LSB = 8;

  typedef struct packed {
    logic [2:0] btn;
    logic [8:0] dy;
    logic [8:0] dx;
  } mouse_evt_t;

  // 18-bit signed leaves headroom for a 16-bit coordinate plus a 9-bit delta.
  function automatic logic [15:0] clamp_coord(input logic signed [17:0] v,
                                              input logic [15:0] maxv);
    logic [15:0] res;
    if (v < 18'sd0)
      res = 16'd0;
    else if (v > $signed({2'b00, maxv}))
      res = maxv;
    else
      res = v[15:0];
    return res;
  endfunction

endpackage

// File: rtl/mouse_event_fifo.sv
// Synchronous FIFO with flush; head is presented combinationally.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module mouse_event_fifo #(
  parameter int DEPTH = 8,
  parameter type T = logic [7:0],
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        push,
  input  T            push_data,
  input  logic        pop,
  output T            head,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  T mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (!do_push && do_pop)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr)
      mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/avalon_mouse_event_queue.sv
// Avalon-MM mouse event queue: buffers decoder packets for software, tracks a
// clamped hardware cursor for the sprite logic and raises a level interrupt.
module avalon_mouse_event_queue
  import mouse_if_pkg::*;
#(
  parameter int COORD_W    = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        avl_read,
  input  logic        avl_write,
  input  logic        avl_cs,
  input  logic [3:0]  avl_byte_en,
  input  logic [3:0]  avl_addr,
  input  logic [31:0] avl_writedata,
  output logic [31:0] avl_readdata,
  input  logic        evt_valid,
  output logic        evt_ready,
  input  logic [8:0]  evt_dx,
  input  logic [8:0]  evt_dy,
  input  logic [2:0]  evt_btn,
  output logic [31:0] export_data,
  output logic [2:0]  export_btn,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] X_MAX = 16'(SCREEN_W - 1);
  localparam logic [15:0] Y_MAX = 16'(SCREEN_H - 1);
  localparam logic [COORD_W-1:0] X_RST = COORD_W'(SCREEN_W / 2);
  localparam logic [COORD_W-1:0] Y_RST = COORD_W'(SCREEN_H / 2);

  logic               ctrl_en, ctrl_irq_en, ovf;
  logic [COORD_W-1:0] pos_x, pos_y;
  logic [2:0]         btn_q;

  logic       wr_en, rd_en, ctrl_wr, pos_wr, clr, ovf_clr, pop, accept, push, drop;
  mouse_evt_t evt_in, head;
  logic       fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  logic [15:0] x_pos16, y_pos16;
  logic [31:0] pos_word, pos_merged;
  logic signed [17:0] x_sum, y_sum;
  logic [15:0] x_move, y_move, x_load, y_load;

  assign wr_en   = avl_cs && avl_write;
  assign rd_en   = avl_cs && avl_read;
  assign ctrl_wr = wr_en && (avl_addr == ADDR_CTRL) && avl_byte_en[0];
  assign clr     = ctrl_wr && avl_writedata[CTRL_CLR];
  assign ovf_clr = wr_en && (avl_addr == ADDR_STAT) && avl_byte_en[0]
                   && avl_writedata[STAT_OVF];
  assign pos_wr  = wr_en && (avl_addr == ADDR_POS);
  assign pop     = rd_en && (avl_addr == ADDR_EVENT);

  // A flush discards the same-cycle event; a full FIFO only drops when no pop frees a slot.
  assign accept  = evt_valid && ctrl_en;
  assign push    = accept && !clr;
  assign drop    = push && fifo_full && !pop;
  assign evt_in  = {evt_btn, evt_dy, evt_dx};

  mouse_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (mouse_evt_t)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (clr),
    .push      (push),
    .push_data (evt_in),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign x_pos16  = 16'(pos_x);
  assign y_pos16  = 16'(pos_y);
  assign pos_word = {y_pos16, x_pos16};

  // Screen y grows downward while the mouse reports positive dy as up.
  assign x_sum  = $signed({2'b00, x_pos16}) + $signed({{9{evt_dx[8]}}, evt_dx});
  assign y_sum  = $signed({2'b00, y_pos16}) - $signed({{9{evt_dy[8]}}, evt_dy});
  assign x_move = clamp_coord(x_sum, X_MAX);
  assign y_move = clamp_coord(y_sum, Y_MAX);

  always_comb begin
    pos_merged = pos_word;
    for (int i = 0; i < 4; i++) begin
      if (avl_byte_en[i])
        pos_merged[8*i +: 8] = avl_writedata[8*i +: 8];
    end
  end

  assign x_load = clamp_coord($signed({2'b00, pos_merged[15:0]}), X_MAX);
  assign y_load = clamp_coord($signed({2'b00, pos_merged[31:16]}), Y_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      ovf         <= 1'b0;
      pos_x       <= X_RST;
      pos_y       <= Y_RST;
      btn_q       <= 3'b000;
    end else begin
      if (ctrl_wr) begin
        ctrl_en     <= avl_writedata[CTRL_EN];
        ctrl_irq_en <= avl_writedata[CTRL_IRQ_EN];
      end
      if (drop)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
      if (pos_wr) begin
        pos_x <= COORD_W'(x_load);
        pos_y <= COORD_W'(y_load);
      end else if (accept) begin
        pos_x <= COORD_W'(x_move);
        pos_y <= COORD_W'(y_move);
      end
      if (accept)
        btn_q <= evt_btn;
    end
  end

  always_comb begin
    avl_readdata = '0;
    if (rd_en) begin
      case (avl_addr)
        ADDR_CTRL: begin
          avl_readdata[CTRL_EN]     = ctrl_en;
          avl_readdata[CTRL_IRQ_EN] = ctrl_irq_en;
        end
        ADDR_STAT: begin
          avl_readdata[STAT_EMPTY] = fifo_empty;
          avl_readdata[STAT_FULL]  = fifo_full;
          avl_readdata[STAT_OVF]   = ovf;
          avl_readdata[STAT_COUNT_LSB +: 8] = 8'(fifo_count);
        end
        ADDR_EVENT: begin
          if (!fifo_empty)
            avl_readdata = {11'b0, head};
        end
        ADDR_POS:   avl_readdata = pos_word;
        default:    avl_readdata = '0;
      endcase
    end
  end

  assign evt_ready   = ctrl_en;
  assign export_data = {x_pos16, y_pos16};
  assign export_btn  = btn_q;
  assign irq         = ctrl_irq_en && (!fifo_empty || ovf);

endmodule

// File: tb/tb_avalon_mouse_event_queue.sv
// Scoreboard bench: stimulus queues expected read data and output snapshots,
// a negedge monitor pops and compares whenever a read or probe is presented.
module tb_avalon_mouse_event_queue;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        avl_read = 1'b0, avl_write = 1'b0, avl_cs = 1'b0;
  logic [3:0]  avl_byte_en = 4'hF;
  logic [3:0]  avl_addr = 4'd0;
  logic [31:0] avl_writedata = 32'd0;
  logic [31:0] avl_readdata;
  logic        evt_valid = 1'b0;
  logic        evt_ready;
  logic [8:0]  evt_dx = 9'd0, evt_dy = 9'd0;
  logic [2:0]  evt_btn = 3'd0;
  logic [31:0] export_data;
  logic [2:0]  export_btn;
  logic        irq;

  avalon_mouse_event_queue dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .avl_read      (avl_read),
    .avl_write     (avl_write),
    .avl_cs        (avl_cs),
    .avl_byte_en   (avl_byte_en),
    .avl_addr      (avl_addr),
    .avl_writedata (avl_writedata),
    .avl_readdata  (avl_readdata),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_dx        (evt_dx),
    .evt_dy        (evt_dy),
    .evt_btn       (evt_btn),
    .export_data   (export_data),
    .export_btn    (export_btn),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] val;
  } rd_exp_t;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [2:0]  btn;
    logic        irq;
    logic        ready;
  } out_exp_t;

  rd_exp_t  rd_q[$];
  out_exp_t out_q[$];
  rd_exp_t  r;
  out_exp_t o;
  int errors = 0;
  int checks = 0;
  logic probe = 1'b0;

  always @(negedge clk) begin
    if (avl_cs && avl_read) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read got=%h", avl_readdata);
      end else begin
        r = rd_q.pop_front();
        if (avl_readdata !== r.val) begin
          errors++;
          $display("FAIL %s readdata got=%h exp=%h", r.name, avl_readdata, r.val);
        end
      end
    end
    if (probe) begin
      checks++;
      if (out_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_probe data=%h", export_data);
      end else begin
        o = out_q.pop_front();
        if (export_data !== o.data || export_btn !== o.btn || irq !== o.irq ||
            evt_ready !== o.ready || (!(avl_cs && avl_read) && avl_readdata !== 32'd0)) begin
          errors++;
          $display("FAIL %s got data=%h btn=%b irq=%b ready=%b rd=%h exp data=%h btn=%b irq=%b ready=%b rd=0",
                   o.name, export_data, export_btn, irq, evt_ready, avl_readdata,
                   o.data, o.btn, o.irq, o.ready);
        end
      end
    end
  end

  task automatic idle();
    avl_cs = 1'b0; avl_read = 1'b0; avl_write = 1'b0; avl_byte_en = 4'hF;
    evt_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
    avl_cs = 1'b1; avl_write = 1'b1; avl_addr = a; avl_writedata = d; avl_byte_en = be;
    step();
    idle();
  endtask

  task automatic rd(input string n, input logic [3:0] a, input logic [31:0] e);
    rd_q.push_back('{n, e});
    avl_cs = 1'b1; avl_read = 1'b1; avl_addr = a;
    step();
    idle();
  endtask

  task automatic set_evt(input logic [8:0] dx, input logic [8:0] dy, input logic [2:0] b);
    evt_valid = 1'b1; evt_dx = dx; evt_dy = dy; evt_btn = b;
  endtask

  task automatic evt(input logic [8:0] dx, input logic [8:0] dy, input logic [2:0] b);
    set_evt(dx, dy, b);
    step();
    idle();
  endtask

  task automatic chk(input string n, input logic [31:0] d, input logic [2:0] b,
                     input logic i, input logic rdy);
    out_q.push_back('{n, d, b, i, rdy});
    probe = 1'b1;
    step();
    probe = 1'b0;
  endtask

  initial begin
    idle();
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // reset state
    chk("reset_out", 32'h0140_00F0, 3'b000, 1'b0, 1'b0);
    rd("reset_stat", 4'd1, 32'h0000_0001);
    rd("reset_ctrl", 4'd0, 32'h0000_0000);
    rd("reset_pos",  4'd3, 32'h00F0_0140);

    // single event
    wr(4'd0, 32'h1);
    evt(9'h005, 9'h003, 3'b001);
    chk("evt1_out", 32'h0145_00ED, 3'b001, 1'b0, 1'b1);
    rd("evt1_stat", 4'd1, 32'h0000_0100);
    rd("evt1_event", 4'd2, 32'h0004_0605);
    rd("evt1_stat_empty", 4'd1, 32'h0000_0001);
    rd("empty_event", 4'd2, 32'h0000_0000);

    // fill past full; 10th overflows in the same cycle as the OVF clear
    for (int i = 0; i < 9; i++) evt(9'h001, 9'h1FF, 3'b100);
    rd("full_stat", 4'd1, 32'h0000_0806);
    avl_cs = 1'b1; avl_write = 1'b1; avl_addr = 4'd1; avl_writedata = 32'h4;
    set_evt(9'h001, 9'h1FF, 3'b100);
    step(); idle();
    rd("ovf_w1c_race", 4'd1, 32'h0000_0806);
    wr(4'd1, 32'h4);
    rd("ovf_cleared", 4'd1, 32'h0000_0802);
    chk("full_out", 32'h014F_00F7, 3'b100, 1'b0, 1'b1);

    // push+pop while full
    rd_q.push_back('{"pop_full", 32'h0013_FE01});
    avl_cs = 1'b1; avl_read = 1'b1; avl_addr = 4'd2;
    set_evt(9'h002, 9'h000, 3'b001);
    step(); idle();
    rd("full_pushpop_stat", 4'd1, 32'h0000_0802);
    for (int i = 0; i < 7; i++) rd("drain", 4'd2, 32'h0013_FE01);
    rd("drain_last", 4'd2, 32'h0004_0002);
    rd("drained_stat", 4'd1, 32'h0000_0001);

    // CLR + push
    evt(9'h001, 9'h000, 3'b010);
    rd("pre_clr_stat", 4'd1, 32'h0000_0100);
    avl_cs = 1'b1; avl_write = 1'b1; avl_addr = 4'd0; avl_writedata = 32'h5;
    set_evt(9'h001, 9'h000, 3'b011);
    step(); idle();
    rd("clr_stat", 4'd1, 32'h0000_0001);
    chk("clr_out", 32'h0153_00F7, 3'b011, 1'b0, 1'b1);
    rd("clr_pos", 4'd3, 32'h00F7_0153);
    rd("clr_ctrl", 4'd0, 32'h0000_0001);

    // position load and clamping
    wr(4'd3, 32'h01D6_027B);
    rd("pos_load", 4'd3, 32'h01D6_027B);
    evt(9'h014, 9'h1EC, 3'b000);
    chk("clamp_high", 32'h027F_01DF, 3'b000, 1'b0, 1'b1);
    wr(4'd3, 32'hFFFF_FFFF);
    rd("pos_load_clamp", 4'd3, 32'h01DF_027F);
    wr(4'd3, 32'h0000_0003, 4'b0011);
    rd("pos_byte_merge", 4'd3, 32'h01DF_0003);
    evt(9'h100, 9'h0FF, 3'b101);
    chk("clamp_low", 32'h0000_00E0, 3'b101, 1'b0, 1'b1);
    avl_cs = 1'b1; avl_write = 1'b1; avl_addr = 4'd3; avl_writedata = 32'h0064_0064;
    set_evt(9'h005, 9'h000, 3'b110);
    step(); idle();
    chk("pos_wins", 32'h0064_0064, 3'b110, 1'b0, 1'b1);
    rd("three_stat", 4'd1, 32'h0000_0300);
    rd("ev_a", 4'd2, 32'h0003_D814);
    rd("ev_b", 4'd2, 32'h0015_FF00);
    rd("ev_c", 4'd2, 32'h0018_0005);
    rd("three_drained", 4'd1, 32'h0000_0001);

    // interrupt
    wr(4'd0, 32'h3);
    chk("irq_idle", 32'h0064_0064, 3'b110, 1'b0, 1'b1);
    evt(9'h000, 9'h000, 3'b111);
    chk("irq_set", 32'h0064_0064, 3'b111, 1'b1, 1'b1);
    rd("irq_event", 4'd2, 32'h001C_0000);
    chk("irq_clear", 32'h0064_0064, 3'b111, 1'b0, 1'b1);

    // EN=0 ignores events; unmapped address reads 0
    wr(4'd0, 32'h2);
    evt(9'h00A, 9'h000, 3'b001);
    chk("en_off", 32'h0064_0064, 3'b111, 1'b0, 1'b0);
    rd("en_off_stat", 4'd1, 32'h0000_0001);
    rd("unmapped", 4'd5, 32'h0000_0000);

    // async reset mid-burst
    wr(4'd0, 32'h3);
    evt(9'h001, 9'h000, 3'b001);
    set_evt(9'h001, 9'h000, 3'b010);
    step();
    #2 reset_n = 1'b0;
    #1 idle();
    chk("in_reset", 32'h0140_00F0, 3'b000, 1'b0, 1'b0);
    reset_n = 1'b1;
    step();
    rd("post_reset_stat", 4'd1, 32'h0000_0001);
    rd("post_reset_ctrl", 4'd0, 32'h0000_0000);
    rd("post_reset_pos", 4'd3, 32'h00F0_0140);

    step();
    step();
    checks++;
    if (rd_q.size() != 0 || out_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations rd=%0d out=%0d exp=0", rd_q.size(), out_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
